// File: rtl/lc3_ctrl_seq_if.sv
// Instruction/memory handshake and status bundle between the LC-3 control
// sequencer and its environment.
interface lc3_ctrl_seq_if #(
    parameter int CW    = 5,
    parameter int CNT_W = 16
);
    logic [15:0]      ir;
    logic             ir_valid;
    logic             ir_ready;
    logic             mem_done;
    logic [CW-1:0]    ctrl;
    logic [2:0]       state;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] retired;

    modport master (
        output ir, ir_valid, mem_done,
        input  ir_ready, ctrl, state, done, err, retired
    );

    modport slave (
        input  ir, ir_valid, mem_done,
        output ir_ready, ctrl, state, done, err, retired
    );
endinterface

// File: rtl/lc3_ctrl_seq.sv
// LC-3 style instruction control sequencer: IDLE -> DECODE -> EXEC -> [MEM] -> [WB],
// with a bounded memory wait, error pulses and a retired-instruction counter.
module lc3_ctrl_seq #(
    parameter int CW     = 5,
    parameter int MEM_TO = 15,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    lc3_ctrl_seq_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TO - 1);

    state_t           state_reg, state_next;
    logic [3:0]       opc_reg, opc_next;
    logic [CW-1:0]    ctrl_reg, ctrl_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic [CNT_W-1:0] retired_reg, retired_next;
    logic [7:0]       wait_reg, wait_next;

    logic [4:0]       dec5;
    logic [CW-1:0]    dec_ctrl;
    logic             is_mem, is_wb, is_rsv;

    always_comb begin
        dec5 = 5'b00000;
        case (opc_reg)
            4'b0000: dec5 = 5'b01000;
            4'b0001: dec5 = 5'b00100;
            4'b0010: dec5 = 5'b01001;
            4'b0011: dec5 = 5'b01100;
            4'b0100: dec5 = 5'b00110;
            4'b0101: dec5 = 5'b00011;
            4'b1001: dec5 = 5'b00101;
            4'b1100: dec5 = 5'b01111;
            default: dec5 = 5'b00000;
        endcase
    end

    // The table is 5 bits wide; fit it to CW by zero-extension or truncation.
    genvar gi;
    generate
        for (gi = 0; gi < CW; gi++) begin : g_ctrl_fit
            if (gi < 5) begin : g_bit
                assign dec_ctrl[gi] = dec5[gi];
            end else begin : g_zero
                assign dec_ctrl[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        is_mem = 1'b0;
        case (opc_reg)
            4'b0010, 4'b0011, 4'b0110,
            4'b0111, 4'b1010, 4'b1011: is_mem = 1'b1;
            default:                   is_mem = 1'b0;
        endcase
    end

    always_comb begin
        is_wb = 1'b0;
        case (opc_reg)
            4'b0001, 4'b0010, 4'b0101, 4'b0110,
            4'b1001, 4'b1010, 4'b1110: is_wb = 1'b1;
            default:                   is_wb = 1'b0;
        endcase
    end

    assign is_rsv = (opc_reg == 4'b1101);

    // Not ready during the retire cycle, so acceptance comes one cycle after done.
    assign bus.ir_ready = (state_reg == S_IDLE) && !done_reg;

    always_comb begin
        state_next   = state_reg;
        opc_next     = opc_reg;
        ctrl_next    = ctrl_reg;
        done_next    = 1'b0;
        err_next     = 1'b0;
        retired_next = retired_reg;
        wait_next    = wait_reg;

        case (state_reg)
            S_IDLE: begin
                if (bus.ir_valid && bus.ir_ready) begin
                    opc_next   = bus.ir[15:12];
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_rsv) begin
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    ctrl_next  = dec_ctrl;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_mem) begin
                    wait_next  = 8'd0;
                    state_next = S_MEM;
                end else if (is_wb) begin
                    state_next = S_WB;
                end else begin
                    done_next    = 1'b1;
                    retired_next = retired_reg + CNT_W'(1);
                    state_next   = S_IDLE;
                end
            end
            S_MEM: begin
                if (bus.mem_done) begin
                    if (is_wb) begin
                        state_next = S_WB;
                    end else begin
                        done_next    = 1'b1;
                        retired_next = retired_reg + CNT_W'(1);
                        state_next   = S_IDLE;
                    end
                end else if (wait_reg == WAIT_LAST) begin
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    wait_next = wait_reg + 8'd1;
                end
            end
            S_WB: begin
                done_next    = 1'b1;
                retired_next = retired_reg + CNT_W'(1);
                state_next   = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (state_next == S_IDLE) begin
            ctrl_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            opc_reg     <= 4'd0;
            ctrl_reg    <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            retired_reg <= '0;
            wait_reg    <= 8'd0;
        end else begin
            state_reg   <= state_next;
            opc_reg     <= opc_next;
            ctrl_reg    <= ctrl_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            retired_reg <= retired_next;
            wait_reg    <= wait_next;
        end
    end

    assign bus.ctrl    = ctrl_reg;
    assign bus.state   = state_reg;
    assign bus.done    = done_reg;
    assign bus.err     = err_reg;
    assign bus.retired = retired_reg;
endmodule

// File: tb/tb_lc3_ctrl_seq.sv
// Directed bench for lc3_ctrl_seq: per-cycle state/ctrl checks plus a scoreboard
// of expected done/err events (kind, cycle, retired count).
module tb_lc3_ctrl_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lc3_ctrl_seq_if #(.CW(5), .CNT_W(16)) bus ();
    lc3_ctrl_seq_if #(.CW(5), .CNT_W(2))  bus2 ();

    lc3_ctrl_seq #(.CW(5), .MEM_TO(15), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    lc3_ctrl_seq #(.CW(5), .MEM_TO(15), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    typedef struct {
        bit is_err;
        int rtd;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_evt(input bit is_err, input int rtd, input int c);
        exp_t e;
        e.is_err = is_err;
        e.rtd    = rtd;
        e.cyc    = c;
        sb.push_back(e);
    endtask

    // Every done/err pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n && (bus.done || bus.err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", {30'd0, bus.done, bus.err}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("evt_kind", {30'd0, bus.done, bus.err}, e.is_err ? 32'd1 : 32'd2);
                chk("evt_cycle", cyc, e.cyc);
                chk("evt_retired", 32'(bus.retired), e.rtd);
            end
        end
    end

    task automatic handshake(input logic [15:0] word, output int t0);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.ir_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hs_ready", bus.ir_ready, 1);
        bus.ir       = word;
        bus.ir_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.ir_valid = 1'b0;
        t0 = cyc;
    endtask

    task automatic step_state(input string tag, input int exp_st);
        @(negedge clk);
        chk(tag, bus.state, exp_st);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int exp_ret;
        int got;

        bus.ir = 16'h0000;   bus.ir_valid = 1'b0;  bus.mem_done = 1'b0;
        bus2.ir = 16'h0000;  bus2.ir_valid = 1'b0; bus2.mem_done = 1'b0;
        exp_ret = 0;

        // Reset values
        #2;
        chk("rst_state", bus.state, 0);
        chk("rst_ctrl", bus.ctrl, 0);
        chk("rst_ready", bus.ir_ready, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_retired", bus.retired, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ADD: DECODE, EXEC, WB, done on cycle 4
        handshake(16'h1042, t0);
        exp_ret = 1;
        expect_evt(1'b0, exp_ret, t0 + 3);
        step_state("add_s1", 1);
        chk("add_ready_busy", bus.ir_ready, 0);
        step_state("add_s2", 2);
        chk("add_ctrl_exec", bus.ctrl, 5'b00100);
        step_state("add_s4", 4);
        chk("add_ctrl_wb", bus.ctrl, 5'b00100);
        step_state("add_idle", 0);
        chk("add_done", bus.done, 1);
        chk("add_ready_in_done", bus.ir_ready, 0);
        chk("add_ctrl_idle", bus.ctrl, 0);
        chk("add_retired", bus.retired, 1);
        @(negedge clk);
        chk("add_done_pulse", bus.done, 0);
        chk("add_ready_after", bus.ir_ready, 1);

        // Reserved opcode: err at cycle 2, ready again, nothing retired
        handshake(16'hD000, t0);
        expect_evt(1'b1, exp_ret, t0 + 1);
        step_state("rsv_s1", 1);
        chk("rsv_ctrl_dec", bus.ctrl, 0);
        step_state("rsv_idle", 0);
        chk("rsv_err", bus.err, 1);
        chk("rsv_done", bus.done, 0);
        chk("rsv_ready", bus.ir_ready, 1);
        chk("rsv_ctrl", bus.ctrl, 0);
        chk("rsv_retired", bus.retired, exp_ret);

        // LD with mem_done on the 3rd MEM cycle; mem_done before MEM is ignored
        bus.mem_done = 1'b1;
        handshake(16'h2005, t0);
        exp_ret++;
        expect_evt(1'b0, exp_ret, t0 + 6);
        step_state("ld_s1", 1);
        step_state("ld_s2", 2);
        chk("ld_ctrl", bus.ctrl, 5'b01001);
        bus.mem_done = 1'b0;
        step_state("ld_m1", 3);
        step_state("ld_m2", 3);
        step_state("ld_m3", 3);
        bus.mem_done = 1'b1;
        step_state("ld_wb", 4);
        bus.mem_done = 1'b0;
        chk("ld_ctrl_wb", bus.ctrl, 5'b01001);
        step_state("ld_idle", 0);
        chk("ld_done", bus.done, 1);

        // ST with mem_done held low: err after 15 MEM cycles
        handshake(16'h3000, t0);
        expect_evt(1'b1, exp_ret, t0 + 17);
        step_state("sto_s1", 1);
        step_state("sto_s2", 2);
        chk("sto_ctrl", bus.ctrl, 5'b01100);
        for (int c = 3; c <= 17; c++) step_state("sto_mem", 3);
        step_state("sto_idle", 0);
        chk("sto_err", bus.err, 1);
        chk("sto_done", bus.done, 0);
        chk("sto_ctrl_idle", bus.ctrl, 0);

        // ST with mem_done exactly on the timeout cycle: mem_done wins
        handshake(16'h3000, t0);
        exp_ret++;
        expect_evt(1'b0, exp_ret, t0 + 17);
        step_state("stl_s1", 1);
        step_state("stl_s2", 2);
        for (int c = 3; c <= 16; c++) step_state("stl_mem", 3);
        step_state("stl_mem_last", 3);
        bus.mem_done = 1'b1;
        step_state("stl_idle", 0);
        bus.mem_done = 1'b0;
        chk("stl_done", bus.done, 1);
        chk("stl_err", bus.err, 0);

        // Reset pulse in MEM: immediate IDLE, no done/err
        handshake(16'h3000, t0);
        step_state("rmem_s1", 1);
        step_state("rmem_s2", 2);
        step_state("rmem_m1", 3);
        step_state("rmem_m2", 3);
        #2 rst_n = 1'b0;
        #1;
        chk("rmem_state", bus.state, 0);
        chk("rmem_ctrl", bus.ctrl, 0);
        chk("rmem_ready", bus.ir_ready, 1);
        chk("rmem_done", bus.done, 0);
        chk("rmem_retired", bus.retired, 0);
        #1 rst_n = 1'b1;
        exp_ret = 0;
        step_state("rmem_stay1", 0);
        step_state("rmem_stay2", 0);

        // BR after reset: no MEM, no WB, done on cycle 3
        handshake(16'h0E01, t0);
        exp_ret = 1;
        expect_evt(1'b0, exp_ret, t0 + 2);
        step_state("br_s1", 1);
        step_state("br_s2", 2);
        chk("br_ctrl", bus.ctrl, 5'b01000);
        step_state("br_idle", 0);
        chk("br_done", bus.done, 1);
        chk("br_retired", bus.retired, 1);

        // Narrow counter wraps: 1,2,3,0,1
        for (int i = 0; i < 5; i++) begin
            int n;
            n = 0;
            @(negedge clk);
            while (!bus2.ir_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            bus2.ir = 16'h0E01;
            bus2.ir_valid = 1'b1;
            @(posedge clk);
            #1;
            bus2.ir_valid = 1'b0;
            got = 0;
            for (int c = 0; c < 10 && got == 0; c++) begin
                @(negedge clk);
                if (bus2.done) got = 1;
            end
            chk("cnt2_done", got, 1);
            chk("cnt2_retired", bus2.retired, (i + 1) % 4);
            $display("cnt2 retire %0d retired=%0d", i, bus2.retired);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
